// File: rtl/unified_memory_ctrl.sv
// Single-ported word RAM shared by the instruction-fetch and data ports.
// Round-robin arbitration, programmable wait states, error pulse on illegal addresses.
module unified_memory_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          WAIT_STATES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        access_err,
    output logic        busy
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic       PORT_INST = 1'b0;
    localparam logic       PORT_DATA = 1'b1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [31:0]   mem_r [DEPTH];
    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    logic          port_r;
    logic          last_grant_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          we_r;

    logic          grant_s;
    logic          grant_port_s;
    logic [31:0]   idx_s;
    logic          legal_s;
    logic [AW-1:0] widx_s;

    // Round-robin pick: on a tie the port that was not served last wins.
    always_comb begin
        grant_s      = inst_req | data_req;
        grant_port_s = PORT_INST;
        if (inst_req && data_req) begin
            grant_port_s = ~last_grant_r;
        end else if (data_req) begin
            grant_port_s = PORT_DATA;
        end else begin
            grant_port_s = PORT_INST;
        end
    end

    // Address decode of the latched request; unsigned compare, no wrap-around.
    always_comb begin
        idx_s   = (addr_r - BASE_ADDR) >> 2;
        legal_s = (addr_r[1:0] == 2'b00) && (addr_r >= BASE_ADDR) && (idx_s < 32'(DEPTH));
        widx_s  = idx_s[AW-1:0];
    end

    // Request FSM: IDLE grants, WAIT burns wait states, ACCESS commits and acks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            port_r       <= PORT_INST;
            last_grant_r <= PORT_INST;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            we_r         <= 1'b0;
            busy         <= 1'b0;
            inst_ack     <= 1'b0;
            data_ack     <= 1'b0;
            access_err   <= 1'b0;
            inst_rdata   <= 32'd0;
            data_rdata   <= 32'd0;
        end else begin
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
            access_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        port_r  <= grant_port_s;
                        addr_r  <= (grant_port_s == PORT_DATA) ? data_addr : inst_addr;
                        we_r    <= (grant_port_s == PORT_DATA) & data_we;
                        wdata_r <= data_wdata;
                        cnt_r   <= WAIT_LOAD;
                        busy    <= 1'b1;
                        state_r <= (WAIT_LOAD == 4'd0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A write leaves both rdata registers untouched.
                    if (!we_r) begin
                        if (port_r == PORT_DATA) begin
                            data_rdata <= legal_s ? mem_r[widx_s] : 32'd0;
                        end else begin
                            inst_rdata <= legal_s ? mem_r[widx_s] : 32'd0;
                        end
                    end
                    inst_ack     <= (port_r == PORT_INST);
                    data_ack     <= (port_r == PORT_DATA);
                    access_err   <= ~legal_s;
                    last_grant_r <= port_r;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port; a write whose commit edge sees reset is discarded.
    always_ff @(posedge clk) begin
        if (reset_n && (state_r == ST_ACCESS) && we_r && legal_s) begin
            mem_r[widx_s] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_unified_memory_ctrl.sv
// Directed bench for unified_memory_ctrl: instance a uses 2 wait states, instance b uses 3.
module tb_unified_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset_n, a_inst_req, a_inst_ack, a_data_req, a_data_we, a_data_ack, a_access_err, a_busy;
    logic [31:0] a_inst_addr, a_inst_rdata, a_data_addr, a_data_wdata, a_data_rdata;
    logic        b_reset_n, b_inst_req, b_inst_ack, b_data_req, b_data_we, b_data_ack, b_access_err, b_busy;
    logic [31:0] b_inst_addr, b_inst_rdata, b_data_addr, b_data_wdata, b_data_rdata;

    unified_memory_ctrl #(.DEPTH(16), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset_n(a_reset_n),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_rdata(a_inst_rdata), .inst_ack(a_inst_ack),
        .data_req(a_data_req), .data_we(a_data_we), .data_addr(a_data_addr), .data_wdata(a_data_wdata),
        .data_rdata(a_data_rdata), .data_ack(a_data_ack), .access_err(a_access_err), .busy(a_busy)
    );

    unified_memory_ctrl #(.DEPTH(16), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .reset_n(b_reset_n),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_rdata(b_inst_rdata), .inst_ack(b_inst_ack),
        .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr), .data_wdata(b_data_wdata),
        .data_rdata(b_data_rdata), .data_ack(b_data_ack), .access_err(b_access_err), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on instance a (b=0) or b (b=1); req dropped in the ack cycle.
    task automatic do_acc(input bit b, input bit port_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                          output int lat, output int busy_cnt);
        bit got;
        logic ack, bsy;
        @(negedge clk);
        if (b) begin
            if (port_d) begin
                b_data_req = 1'b1; b_data_we = we; b_data_addr = addr; b_data_wdata = wdata;
            end else begin
                b_inst_req = 1'b1; b_inst_addr = addr;
            end
        end else begin
            if (port_d) begin
                a_data_req = 1'b1; a_data_we = we; a_data_addr = addr; a_data_wdata = wdata;
            end else begin
                a_inst_req = 1'b1; a_inst_addr = addr;
            end
        end
        got = 1'b0; lat = 0; busy_cnt = 0; rdata = 32'd0; err = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            ack = b ? (port_d ? b_data_ack : b_inst_ack) : (port_d ? a_data_ack : a_inst_ack);
            bsy = b ? b_busy : a_busy;
            if (ack) begin
                got   = 1'b1;
                lat   = i;
                rdata = b ? (port_d ? b_data_rdata : b_inst_rdata) : (port_d ? a_data_rdata : a_inst_rdata);
                err   = b ? b_access_err : a_access_err;
                if (b) begin b_inst_req = 1'b0; b_data_req = 1'b0; end
                else   begin a_inst_req = 1'b0; a_data_req = 1'b0; end
            end else if (bsy) begin
                busy_cnt++;
            end
        end
        check_eq("ack_seen", 32'(got), 32'd1);
    endtask

    // Hold instance a in reset for two edges with random inputs, then check outputs.
    task automatic reset_a_check();
        @(negedge clk);
        a_reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_inst_req = 1'($urandom); a_data_req = 1'($urandom); a_data_we = 1'($urandom);
            a_inst_addr = $urandom; a_data_addr = $urandom; a_data_wdata = $urandom;
            @(negedge clk);
        end
        check_eq("rst_inst_ack", 32'(a_inst_ack), 32'd0);
        check_eq("rst_data_ack", 32'(a_data_ack), 32'd0);
        check_eq("rst_err", 32'(a_access_err), 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_inst_rdata", a_inst_rdata, 32'd0);
        check_eq("rst_data_rdata", a_data_rdata, 32'd0);
        a_reset_n = 1'b1; a_inst_req = 1'b0; a_data_req = 1'b0; a_data_we = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(a_busy), 32'd0);
    endtask

    // Start a write on instance b and pull reset after rst_at negedges; no ack may follow.
    task automatic abort_write_b(input int rst_at, input logic [31:0] addr, input logic [31:0] wdata);
        bit seen;
        @(negedge clk);
        b_data_req = 1'b1; b_data_we = 1'b1; b_data_addr = addr; b_data_wdata = wdata;
        for (int i = 1; i <= rst_at; i++) begin
            @(negedge clk);
            if (i == 1) check_eq("abort_busy_inflight", 32'(b_busy), 32'd1);
        end
        b_reset_n = 1'b0; b_data_req = 1'b0; b_data_we = 1'b0;
        @(negedge clk);
        seen = b_data_ack;
        b_reset_n = 1'b1;
        @(negedge clk);
        check_eq("abort_busy_after_rst", 32'(b_busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (b_data_ack) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("abort_no_ack", 32'(seen), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, bc;
    int          n_acks;
    bit          overlap;
    int          ack_port [4];
    int          ack_cyc  [4];

    initial begin
        a_reset_n = 1'b0; a_inst_req = 1'b0; a_data_req = 1'b0; a_data_we = 1'b0;
        a_inst_addr = 32'd0; a_data_addr = 32'd0; a_data_wdata = 32'd0;
        b_reset_n = 1'b0; b_inst_req = 1'b0; b_data_req = 1'b0; b_data_we = 1'b0;
        b_inst_addr = 32'd0; b_data_addr = 32'd0; b_data_wdata = 32'd0;
        repeat (2) @(negedge clk);
        b_reset_n = 1'b1;

        reset_a_check();

        // Fetch latency: place the word, then fetch it.
        do_acc(1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h2008_0005, rd, er, lat, bc);
        check_eq("preload_err", 32'(er), 32'd0);
        do_acc(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'd0, rd, er, lat, bc);
        check_eq("fetch_rdata", rd, 32'h2008_0005);
        check_eq("fetch_latency", 32'(lat), 32'd4);
        check_eq("fetch_busy_cycles", 32'(bc), 32'd3);
        @(negedge clk);
        check_eq("fetch_ack_one_cycle", 32'(a_inst_ack), 32'd0);

        // Write then read; the write ack must not disturb data_rdata.
        do_acc(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'd0, rd, er, lat, bc);
        check_eq("rd0_rdata", rd, 32'h2008_0005);
        do_acc(1'b0, 1'b1, 1'b1, 32'h0000_3010, 32'hDEAD_BEEF, rd, er, lat, bc);
        check_eq("wr_keeps_rdata", rd, 32'h2008_0005);
        check_eq("wr_err", 32'(er), 32'd0);
        do_acc(1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'd0, rd, er, lat, bc);
        check_eq("rd_back", rd, 32'hDEAD_BEEF);
        check_eq("rd_back_err", 32'(er), 32'd0);

        reset_a_check();

        // Round robin with both ports held high right after reset.
        @(negedge clk);
        a_inst_req = 1'b1; a_inst_addr = 32'h0000_3000;
        a_data_req = 1'b1; a_data_we = 1'b0; a_data_addr = 32'h0000_3010;
        n_acks = 0; overlap = 1'b0;
        for (int c = 1; c <= 40 && n_acks < 4; c++) begin
            @(negedge clk);
            if (a_inst_ack && a_data_ack) overlap = 1'b1;
            if (a_inst_ack || a_data_ack) begin
                ack_port[n_acks] = a_data_ack ? 1 : 0;
                ack_cyc[n_acks]  = c;
                if (a_data_ack) check_eq("rr_data_rdata", a_data_rdata, 32'hDEAD_BEEF);
                else            check_eq("rr_inst_rdata", a_inst_rdata, 32'h2008_0005);
                n_acks++;
                if (n_acks == 4) begin a_inst_req = 1'b0; a_data_req = 1'b0; end
            end
        end
        check_eq("rr_count", 32'(n_acks), 32'd4);
        check_eq("rr_overlap", 32'(overlap), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_order", 32'(ack_port[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_spacing", 32'(ack_cyc[k]), 32'(4 * (k + 1)));
        end

        // Illegal addresses against a fully known memory image.
        for (int i = 0; i < 16; i++) begin
            do_acc(1'b0, 1'b1, 1'b1, 32'h0000_3000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), rd, er, lat, bc);
        end
        do_acc(1'b0, 1'b1, 1'b0, 32'h0000_2FFC, 32'd0, rd, er, lat, bc);
        check_eq("below_base_err", 32'(er), 32'd1);
        check_eq("below_base_rdata", rd, 32'd0);
        do_acc(1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'd0, rd, er, lat, bc);
        check_eq("misalign_err", 32'(er), 32'd1);
        check_eq("misalign_rdata", rd, 32'd0);
        do_acc(1'b0, 1'b1, 1'b1, 32'h0000_3040, 32'h1234_5678, rd, er, lat, bc);
        check_eq("past_end_err", 32'(er), 32'd1);
        for (int i = 0; i < 16; i++) begin
            do_acc(1'b0, 1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'd0, rd, er, lat, bc);
            check_eq("scan", rd, 32'hA5A5_0000 + 32'(i));
        end
        do_acc(1'b0, 1'b1, 1'b0, 32'h0000_303C, 32'd0, rd, er, lat, bc);
        check_eq("last_word_err", 32'(er), 32'd0);

        // Reset mid-write and on the commit edge, three wait states.
        do_acc(1'b1, 1'b1, 1'b1, 32'h0000_3004, 32'h1111_2222, rd, er, lat, bc);
        check_eq("b_preload_err", 32'(er), 32'd0);
        check_eq("b_latency", 32'(lat), 32'd5);
        abort_write_b(2, 32'h0000_3004, 32'hCAFE_F00D);
        do_acc(1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'd0, rd, er, lat, bc);
        check_eq("b_after_wait_abort", rd, 32'h1111_2222);
        abort_write_b(4, 32'h0000_3004, 32'hCAFE_F00D);
        do_acc(1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'd0, rd, er, lat, bc);
        check_eq("b_after_access_abort", rd, 32'h1111_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
